// File: rtl/sd_host_reg_bank.sv
// SD host-controller register bank: CPU access with byte enables, RO/W1C/self-clearing
// register classes, hardware update port and interrupt status/enable/signal logic.
module sd_host_reg_bank #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned NUM_REGS   = 25,
  parameter logic [31:0] CAPS_RESET = 32'h0000_0000,
  parameter logic [15:0] VERSION    = 16'h0001
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req,
  input  logic                    rw,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [DATA_WIDTH-1:0]   data_in,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    ack,
  input  logic                    hw_we,
  input  logic [ADDR_WIDTH-1:0]   hw_addr,
  input  logic [DATA_WIDTH-1:0]   hw_data,
  input  logic [31:0]             irq_set,
  output logic                    irq,
  output logic                    cmd_start,
  output logic [7:0]              sw_reset
);

  localparam int unsigned NB = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] A_CMD  = ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] A_SRST = ADDR_WIDTH'(11);
  localparam logic [ADDR_WIDTH-1:0] A_ISTS = ADDR_WIDTH'(12);

  logic [DATA_WIDTH-1:0] regs     [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_nxt [NUM_REGS];
  logic [DATA_WIDTH-1:0] wmask;
  logic [DATA_WIDTH-1:0] clr_mask;
  logic [DATA_WIDTH-1:0] ists_view;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  cpu_wr;
  logic                  cpu_ok;
  logic                  hw_ok;

  function automatic logic is_ro(input logic [ADDR_WIDTH-1:0] a);
    logic [31:0] ai;
    ai = 32'(a);
    return (ai >= 32'd4 && ai <= 32'd9) || (ai >= 32'd15 && ai <= 32'd19) || ai == 32'd21;
  endfunction

  // Bit 15 of the interrupt status is a live summary of the upper (error) half.
  assign ists_view = {regs[12][DATA_WIDTH-1:16], |regs[12][DATA_WIDTH-1:16], regs[12][14:0]};

  assign cpu_wr = req && !rw;
  assign cpu_ok = 32'(addr) < NUM_REGS;
  assign hw_ok  = hw_we && (32'(hw_addr) < NUM_REGS) && is_ro(hw_addr);

  always_comb begin
    rd_word = '0;
    if (cpu_ok) rd_word = (addr == A_ISTS) ? ists_view : regs[addr];
  end

  // Next register contents: CPU write, status set/clear, then hardware update last.
  always_comb begin
    regs_nxt = regs;
    wmask    = '0;
    for (int unsigned k = 0; k < NB; k++) wmask[8*k +: 8] = {8{be[k]}};
    clr_mask = (cpu_wr && addr == A_ISTS) ? (data_in & wmask) : '0;
    if (cpu_wr && cpu_ok && !is_ro(addr) && addr != A_ISTS)
      regs_nxt[addr] = (regs[addr] & ~wmask) | (data_in & wmask);
    regs_nxt[12] = (regs[12] & ~clr_mask) | (DATA_WIDTH'(irq_set) & regs[13]);
    regs_nxt[12][15] = 1'b0;
    regs_nxt[11][31:24] = 8'h00;
    if (hw_ok) regs_nxt[hw_addr] = hw_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      regs[16]  <= DATA_WIDTH'(CAPS_RESET);
      regs[19]  <= DATA_WIDTH'({VERSION, 16'h0000});
      data_out  <= '0;
      ack       <= 1'b0;
      irq       <= 1'b0;
      cmd_start <= 1'b0;
      sw_reset  <= 8'h00;
    end else begin
      regs      <= regs_nxt;
      ack       <= req;
      if (req && rw) data_out <= rd_word;
      irq       <= |(ists_view & regs[14]);
      cmd_start <= cpu_wr && (addr == A_CMD) && be[3];
      sw_reset  <= (cpu_wr && (addr == A_SRST) && be[3]) ? data_in[31:24] : 8'h00;
    end
  end

endmodule

// File: tb/tb_sd_host_reg_bank.sv
// Self-checking bench for sd_host_reg_bank: per-cycle model comparison plus directed
// literal checks of the documented scenarios.
module tb_sd_host_reg_bank;

  localparam logic [31:0] CAPS = 32'hCAFE_0123;
  localparam logic [15:0] VER  = 16'h0001;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0, rw = 1'b0, hw_we = 1'b0;
  logic [4:0]  addr = '0, hw_addr = '0;
  logic [3:0]  be = '0;
  logic [31:0] data_in = '0, hw_data = '0, irq_set = '0;
  logic [31:0] data_out;
  logic        ack, irq, cmd_start;
  logic [7:0]  sw_reset;

  int checks = 0;
  int errors = 0;

  sd_host_reg_bank #(
    .DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_REGS(25), .CAPS_RESET(CAPS), .VERSION(VER)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .rw(rw), .addr(addr), .be(be),
    .data_in(data_in), .data_out(data_out), .ack(ack), .hw_we(hw_we),
    .hw_addr(hw_addr), .hw_data(hw_data), .irq_set(irq_set), .irq(irq),
    .cmd_start(cmd_start), .sw_reset(sw_reset)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: register contents as plain words, classes by address sets.
  logic [31:0] m [25];
  logic [31:0] e_dout, e_sw;
  logic        e_ack, e_irq, e_cmd;
  bit          model_valid = 0;

  function automatic logic [31:0] mread(input int a);
    logic [31:0] v;
    if (a >= 25) return 32'h0;
    v = m[a];
    if (a == 12) v[15] = |v[31:16];
    return v;
  endfunction

  always @(posedge clk) begin
    logic [31:0] n [25];
    int a;
    a = int'(addr);
    model_valid = 1;
    if (reset) begin
      foreach (m[i]) m[i] = 32'h0;
      m[16] = CAPS;
      m[19] = {VER, 16'h0000};
      e_dout = 0; e_ack = 0; e_irq = 0; e_cmd = 0; e_sw = 0;
    end else begin
      e_ack = req;
      if (req && rw) e_dout = mread(a);
      e_cmd = req && !rw && a == 3 && be[3];
      e_sw  = (req && !rw && a == 11 && be[3]) ? {24'h0, data_in[31:24]} : 32'h0;
      e_irq = |(mread(12) & m[14]);
      n = m;
      if (req && !rw && a < 25) begin
        for (int k = 0; k < 4; k++) begin
          if (!be[k]) continue;
          if (a == 12) begin
            for (int b = 8*k; b < 8*k+8; b++) if (data_in[b]) n[12][b] = 1'b0;
          end else if (!(a inside {[4:9], [15:19], 21})) begin
            n[a][8*k +: 8] = data_in[8*k +: 8];
          end
        end
      end
      for (int b = 0; b < 32; b++) if (irq_set[b] && m[13][b]) n[12][b] = 1'b1;
      n[12][15] = 1'b0;
      n[11][31:24] = 8'h00;
      if (hw_we && int'(hw_addr) inside {[4:9], [15:19], 21}) n[int'(hw_addr)] = hw_data;
      m = n;
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      chk("ack", {31'h0, ack}, {31'h0, e_ack});
      chk("data_out", data_out, e_dout);
      chk("irq", {31'h0, irq}, {31'h0, e_irq});
      chk("cmd_start", {31'h0, cmd_start}, {31'h0, e_cmd});
      chk("sw_reset", {24'h0, sw_reset}, e_sw);
    end
  end

  task automatic cpu_write(input int a, input logic [31:0] d, input logic [3:0] b);
    req = 1; rw = 0; addr = 5'(a); data_in = d; be = b;
    @(negedge clk);
    req = 0; be = '0;
  endtask

  task automatic cpu_read(input int a, output logic [31:0] d);
    req = 1; rw = 1; addr = 5'(a);
    @(negedge clk);
    d = data_out;
    chk("read_ack", {31'h0, ack}, 32'h1);
    req = 0;
  endtask

  initial begin
    logic [31:0] rd;
    repeat (2) @(negedge clk);
    chk("rst_ack", {31'h0, ack}, 32'h0);
    chk("rst_dout", data_out, 32'h0);
    reset = 0;

    // Reset values
    cpu_read(16, rd); chk("caps", rd, CAPS);
    cpu_read(19, rd); chk("version", {16'h0, rd[31:16]}, {16'h0, VER});

    // Byte-enabled write
    cpu_write(2, 32'hAABBCCDD, 4'b0101);
    cpu_read(2, rd); chk("byte_en", rd, 32'h00BB00DD);

    // RO ignores CPU, takes hardware
    cpu_write(5, 32'hFFFFFFFF, 4'b1111);
    chk("ro_write_ack", {31'h0, ack}, 32'h1);
    cpu_read(5, rd); chk("ro_cpu_ignored", rd, 32'h0);
    hw_we = 1; hw_addr = 5'd5; hw_data = 32'h1234;
    @(negedge clk); hw_we = 0;
    cpu_read(5, rd); chk("ro_hw_write", rd, 32'h1234);
    hw_we = 1; hw_addr = 5'd2; hw_data = 32'hFFFF_FFFF;
    @(negedge clk); hw_we = 0;
    cpu_read(2, rd); chk("hw_rw_ignored", rd, 32'h00BB00DD);

    // Interrupt status / enable / signal
    cpu_write(13, 32'h1, 4'hF);
    cpu_write(14, 32'h1, 4'hF);
    irq_set = 32'h1; @(negedge clk); irq_set = 0;
    @(negedge clk);
    chk("irq_asserted", {31'h0, irq}, 32'h1);
    cpu_read(12, rd); chk("ists_set", rd, 32'h1);
    cpu_write(12, 32'h1, 4'hF);
    cpu_read(12, rd); chk("ists_w1c", rd, 32'h0);
    chk("irq_cleared", {31'h0, irq}, 32'h0);
    irq_set = 32'h1; cpu_write(12, 32'h1, 4'hF); irq_set = 0;
    cpu_read(12, rd); chk("set_wins", rd, 32'h1);
    cpu_write(13, 32'h0001_8001, 4'hF);
    irq_set = 32'h0001_8000; @(negedge clk); irq_set = 0;
    cpu_read(12, rd); chk("ists_bit15", rd, 32'h0001_8001);

    // Command start strobe, back-to-back writes give separate pulses
    cpu_write(3, 32'h1100_0000, 4'b1000);
    chk("cmd_pulse", {31'h0, cmd_start}, 32'h1);
    @(negedge clk);
    chk("cmd_pulse_end", {31'h0, cmd_start}, 32'h0);
    cpu_read(3, rd); chk("cmd_reg", rd, 32'h1100_0000);
    cpu_write(3, 32'h2200_0000, 4'b1000);
    cpu_write(3, 32'h3300_0000, 4'b1000);
    chk("cmd_second", {31'h0, cmd_start}, 32'h1);
    cpu_write(3, 32'h4400_0055, 4'b0001);
    chk("cmd_no_be3", {31'h0, cmd_start}, 32'h0);

    // Software reset strobe and out-of-range address
    cpu_write(11, 32'h0700_00AB, 4'b1111);
    chk("sw_reset", {24'h0, sw_reset}, 32'h07);
    @(negedge clk);
    chk("sw_reset_end", {24'h0, sw_reset}, 32'h0);
    cpu_read(11, rd); chk("srst_not_stored", rd, 32'h0000_00AB);
    cpu_write(30, 32'hDEAD_BEEF, 4'hF);
    chk("oor_ack", {31'h0, ack}, 32'h1);
    cpu_read(30, rd); chk("oor_read", rd, 32'h0);

    // Sweep all addresses; the model checks each cycle
    for (int a = 0; a < 26; a++) cpu_write(a, 32'h0101_0101 * a, 4'hF);
    for (int a = 0; a < 26; a++) cpu_read(a, rd);
    cpu_read(20, rd); chk("sweep_rw20", rd, 32'h1414_1414);

    // Reset during a command write: no ack, no strobe
    req = 1; rw = 0; addr = 5'd3; be = 4'b1000; data_in = 32'h5500_0000; reset = 1;
    @(negedge clk);
    chk("rst_mid_ack", {31'h0, ack}, 32'h0);
    chk("rst_mid_cmd", {31'h0, cmd_start}, 32'h0);
    req = 0; reset = 0;
    @(negedge clk);
    chk("rst_after_cmd", {31'h0, cmd_start}, 32'h0);
    cpu_read(3, rd); chk("rst_reg3", rd, 32'h0);
    cpu_read(16, rd); chk("rst_caps", rd, CAPS);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
